key_encoder: RTL and testbench

KEY_ENCODER -- requirements
Module: key_encoder

---
 rtl/key_pkg.sv | 14 +
 rtl/tick_gen.sv | 32 +++
 rtl/key_encoder.sv | 137 +++++++++++++
 tb/tb_key_encoder.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and widths for the debounced push-button encoder.
package key_pkg;

  localparam int unsigned KEY_W  = 8;
  localparam int unsigned CODE_W = 3;

  typedef enum logic [1:0] {
    StIdle,
    StPress,
    StHeld,
    StRelease
  } key_state_e;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks, restarted by reset.
module tick_gen #(
  parameter int unsigned DIV = 62500
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/key_encoder.sv
// Eight-button priority encoder with synchronizer, tick-based debounce and a
// one-cycle press strobe on acceptance.
module key_encoder
  import key_pkg::*;
#(
  parameter int unsigned TICK_DIV       = 62500,
  parameter int unsigned DEBOUNCE_TICKS = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [KEY_W-1:0]  key,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic              press
);

  localparam logic [7:0] DbMax = 8'(DEBOUNCE_TICKS - 1);

  logic [KEY_W-1:0]  sync1_q, sync2_q;
  logic [KEY_W-1:0]  act;
  logic              any;
  logic [CODE_W-1:0] raw;
  logic              tick;

  key_state_e        state_q, state_d;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [7:0]        db_cnt_q, db_cnt_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              press_q, press_d;

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign act = ~sync2_q;
  assign any = |act;

  // Ascending scan so the highest set bit wins.
  always_comb begin
    raw = '0;
    for (int i = 0; i < KEY_W; i++) begin
      if (act[i]) begin
        raw = CODE_W'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    db_cnt_d = db_cnt_q;
    code_d   = code_q;
    valid_d  = valid_q;
    press_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any) begin
          state_d  = StPress;
          cand_d   = raw;
          db_cnt_d = '0;
        end
      end
      StPress: begin
        if (!any) begin
          state_d  = StIdle;
          db_cnt_d = '0;
        end else if (raw != cand_q) begin
          cand_d   = raw;
          db_cnt_d = '0;
        end else if (tick) begin
          if (db_cnt_q == DbMax) begin
            state_d  = StHeld;
            code_d   = cand_q;
            valid_d  = 1'b1;
            press_d  = 1'b1;
            db_cnt_d = '0;
          end else begin
            db_cnt_d = db_cnt_q + 8'd1;
          end
        end
      end
      StHeld: begin
        if (!any) begin
          state_d  = StRelease;
          db_cnt_d = '0;
        end
      end
      StRelease: begin
        if (any) begin
          state_d  = StHeld;
          db_cnt_d = '0;
        end else if (tick) begin
          if (db_cnt_q == DbMax) begin
            state_d  = StIdle;
            valid_d  = 1'b0;
            db_cnt_d = '0;
          end else begin
            db_cnt_d = db_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      state_q  <= StIdle;
      cand_q   <= '0;
      db_cnt_q <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= key;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      cand_q   <= cand_d;
      db_cnt_q <= db_cnt_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      press_q  <= press_d;
    end
  end

  assign code  = code_q;
  assign valid = valid_q;
  assign press = press_q;

endmodule

// File: tb/tb_key_encoder.sv
// Directed bench for key_encoder with TICK_DIV=4, DEBOUNCE_TICKS=3.
module tb_key_encoder;

  localparam int unsigned TickDiv = 4;
  localparam int unsigned DbTicks = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] key = 8'hFF;
  logic [2:0] code;
  logic       valid;
  logic       press;

  int checks = 0;
  int errors = 0;
  int press_cnt = 0;
  int consec_cnt = 0;
  int valid_low_cnt = 0;
  logic press_prev = 1'b0;

  key_encoder #(
    .TICK_DIV       (TickDiv),
    .DEBOUNCE_TICKS (DbTicks)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .key   (key),
    .code  (code),
    .valid (valid),
    .press (press)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (press) press_cnt++;
    if (press && press_prev) consec_cnt++;
    if (!valid) valid_low_cnt++;
    press_prev = press;
  end

  typedef struct {
    logic [7:0] key;
    int         cycles;
    logic [2:0] code;
    logic       valid;
    int         presses;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int lat;
    // Sequential records; each starts from the state the previous one left.
    vecs[0] = '{key: 8'hFF, cycles: 100, code: 3'd0, valid: 1'b0, presses: 0};
    vecs[1] = '{key: 8'hFB, cycles: 16,  code: 3'd2, valid: 1'b1, presses: 1};
    vecs[2] = '{key: 8'hFB, cycles: 20,  code: 3'd2, valid: 1'b1, presses: 0};
    vecs[3] = '{key: 8'hFF, cycles: 20,  code: 3'd2, valid: 1'b0, presses: 0};
    vecs[4] = '{key: 8'h7E, cycles: 16,  code: 3'd7, valid: 1'b1, presses: 1};
    vecs[5] = '{key: 8'hFE, cycles: 20,  code: 3'd7, valid: 1'b1, presses: 0};
    vecs[6] = '{key: 8'hFF, cycles: 20,  code: 3'd7, valid: 1'b0, presses: 0};

    step(3);
    check("reset_code", int'(code), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_press", int'(press), 0);
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      key = vecs[v].key;
      press_cnt = 0;
      step(vecs[v].cycles);
      check($sformatf("vec%0d_code", v), int'(code), int'(vecs[v].code));
      check($sformatf("vec%0d_valid", v), int'(valid), int'(vecs[v].valid));
      check($sformatf("vec%0d_presses", v), press_cnt, vecs[v].presses);
    end

    // Bounce on key2: pressed/released every 3 cycles never completes debounce.
    press_cnt = 0;
    valid_low_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      key = 8'hFB;
      step(3);
      key = 8'hFF;
      step(3);
    end
    check("bounce_presses", press_cnt, 0);
    check("bounce_valid_low_cycles", valid_low_cnt, 60);
    key = 8'hFB;
    step(16);
    check("bounce_then_hold_presses", press_cnt, 1);
    check("bounce_then_hold_code", int'(code), 2);
    check("bounce_then_hold_valid", int'(valid), 1);

    // Short release glitch while held.
    press_cnt = 0;
    valid_low_cnt = 0;
    key = 8'hFF;
    step(2);
    key = 8'hFB;
    step(20);
    check("glitch_valid_low_cycles", valid_low_cnt, 0);
    check("glitch_presses", press_cnt, 0);
    check("glitch_code", int'(code), 2);

    // Reset pulse mid-debounce, then re-acceptance timing.
    key = 8'hFF;
    step(20);
    check("pre_rst_valid", int'(valid), 0);
    press_cnt = 0;
    key = 8'hFB;
    step(5);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst_pulse_code", int'(code), 0);
    check("rst_pulse_valid", int'(valid), 0);
    check("rst_pulse_presses", press_cnt, 0);
    // 2 sync + 1 idle->press + 3 ticks, first tick 4 edges after reset.
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (press) begin
        lat = n;
        break;
      end
    end
    check("rst_reaccept_latency", lat, 12);
    step(2);
    check("rst_reaccept_presses", press_cnt, 1);
    check("rst_reaccept_code", int'(code), 2);

    check("press_consecutive", consec_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
